// File: rtl/pool_window_buffer_2x2.sv
// ---------------------------------------------------------------------------
// pool_window_buffer_2x2
//
// Streaming window generator placed in front of the 2x2 max-pooling stage.
// It takes a raster-order pixel stream, keeps one even row in a line buffer,
// and emits each non-overlapping 2x2 block (stride 2) as four parallel pixels.
// One window is produced for every four accepted pixels.
//
// Parameters:
//   DATA_WIDTH  bits per pixel
//   IMG_WIDTH   pixels per row (even, >= 2)
//   IMG_HEIGHT  rows per frame (even, >= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_pixel   incoming pixel, raster order
//   in_valid   in_pixel is valid
//   in_ready   block accepts a pixel this cycle
//   win_00     top-left pixel of the window
//   win_01     top-right pixel of the window
//   win_10     bottom-left pixel of the window
//   win_11     bottom-right pixel of the window
//   win_valid  window outputs are valid
//   win_ready  downstream accepts the window
//   win_last   current window is the last one of the frame
// ---------------------------------------------------------------------------
module pool_window_buffer_2x2 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] win_00,
  output logic [DATA_WIDTH-1:0] win_01,
  output logic [DATA_WIDTH-1:0] win_10,
  output logic [DATA_WIDTH-1:0] win_11,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col_pair;
  logic [DATA_WIDTH-1:0] linebuf [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] hold_reg;
  logic                  in_xfer;
  logic                  row_odd;
  logic                  col_odd;
  logic                  col_last;
  logic                  row_last;
  logic                  win_load;

  // Any pending window that is not being taken this cycle blocks the input,
  // even if the next pixel would not complete a new window.
  assign in_ready = !win_valid || win_ready;
  assign in_xfer  = in_valid && in_ready;

  assign row_odd  = row[0];
  assign col_odd  = col[0];
  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);
  assign win_load = in_xfer && row_odd && col_odd;

  // When a window completes, col is odd, so the left column of the block is
  // col with its LSB cleared; this avoids a subtractor.
  always_comb begin
    col_pair    = col;
    col_pair[0] = 1'b0;
  end

  // Raster position of the next pixel to be accepted. Wrapping the row at the
  // end of the frame lets the next frame start on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // The top row of every block pair lives here until the matching bottom row
  // arrives; its contents never need a reset because each entry is written
  // before it is read.
  always_ff @(posedge clk) begin
    if (in_xfer && !row_odd) begin
      linebuf[col] <= in_pixel;
    end
  end

  // Bottom-left pixel of the current block, held until the bottom-right pixel
  // completes the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (in_xfer && row_odd && !col_odd) begin
      hold_reg <= in_pixel;
    end
  end

  // Output register. A new window can only load when in_ready is high, so it
  // never overwrites a window the consumer has not taken; loading while the
  // old one is accepted keeps win_valid high for full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_00    <= '0;
      win_01    <= '0;
      win_10    <= '0;
      win_11    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (win_load) begin
      win_00    <= linebuf[col_pair];
      win_01    <= linebuf[col];
      win_10    <= hold_reg;
      win_11    <= in_pixel;
      win_valid <= 1'b1;
      win_last  <= row_last && col_last;
    end else if (win_valid && win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_window_buffer_2x2.sv
// ---------------------------------------------------------------------------
// tb_pool_window_buffer_2x2
//
// Self-checking bench for pool_window_buffer_2x2. A 4x4 instance covers the
// small-frame scenarios and an 8x8 instance covers the default geometry.
// Expected windows are derived from the frame contents by block arithmetic.
// ---------------------------------------------------------------------------
module tb_pool_window_buffer_2x2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 4x4 instance signals
  logic [7:0] in_pixel_a;
  logic       in_valid_a;
  logic       in_ready_a;
  logic [7:0] w00_a, w01_a, w10_a, w11_a;
  logic       win_valid_a;
  logic       win_ready_a;
  logic       win_last_a;

  // 8x8 instance signals
  logic [7:0] in_pixel_b;
  logic       in_valid_b;
  logic       in_ready_b;
  logic [7:0] w00_b, w01_b, w10_b, w11_b;
  logic       win_valid_b;
  logic       win_ready_b;
  logic       win_last_b;

  pool_window_buffer_2x2 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_pixel(in_pixel_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .win_00(w00_a), .win_01(w01_a), .win_10(w10_a), .win_11(w11_a),
    .win_valid(win_valid_a), .win_ready(win_ready_a), .win_last(win_last_a)
  );

  pool_window_buffer_2x2 #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_pixel(in_pixel_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .win_00(w00_b), .win_01(w01_b), .win_10(w10_b), .win_11(w11_b),
    .win_valid(win_valid_b), .win_ready(win_ready_b), .win_last(win_last_b)
  );

  int total = 0;
  int bad   = 0;

  // Frame source pixels and observations of the 4x4 instance
  logic [7:0]  src_q[$];
  logic [31:0] obs_w[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  logic        tr_inrdy[$];
  logic        tr_v[$];
  logic        tr_r[$];
  logic [31:0] tr_d[$];

  // Reference: window k of a stream of w x h frames is block k within its
  // frame, read straight out of the source pixel list.
  function automatic void expect_win(input int w, input int h, input int k,
                                     output logic [31:0] d, output logic last,
                                     output int comp);
    int nb, f, b, br, bc, o;
    nb   = (w / 2) * (h / 2);
    f    = k / nb;
    b    = k % nb;
    br   = b / (w / 2);
    bc   = b % (w / 2);
    o    = f * w * h + 2 * br * w + 2 * bc;
    d    = {src_q[o], src_q[o + 1], src_q[o + w], src_q[o + w + 1]};
    last = (b == nb - 1);
    comp = o + w + 1;
  endfunction

  function automatic void clear_obs();
    obs_w.delete();
    obs_last.delete();
    obs_cyc.delete();
    acc_cyc.delete();
    tr_inrdy.delete();
    tr_v.delete();
    tr_r.delete();
    tr_d.delete();
  endfunction

  // Streams src_q[0..npix-1] into the 4x4 instance and records what happens.
  // mode 0: ready always high; 1: ready low for stall_len cycles starting when
  // the 6th pixel is in; 2: ready toggles; 3: ready always low.
  task automatic stream_a(input int npix, input int valid_pct, input int mode,
                          input int stall_len);
    int idx        = 0;
    int cyc        = 0;
    int tail       = 0;
    int stall_used = 0;
    clear_obs();
    while ((idx < npix || tail < 6) && cyc < 600) begin
      if (idx < npix && $urandom_range(99) < valid_pct) begin
        in_valid_a = 1'b1;
        in_pixel_a = src_q[idx];
      end else begin
        in_valid_a = 1'b0;
        in_pixel_a = 8'h00;
      end
      case (mode)
        1: begin
          if (acc_cyc.size() >= 6 && stall_used < stall_len) begin
            win_ready_a = 1'b0;
            stall_used++;
          end else begin
            win_ready_a = 1'b1;
          end
        end
        2:       win_ready_a = (cyc % 2 == 0);
        3:       win_ready_a = 1'b0;
        default: win_ready_a = 1'b1;
      endcase
      @(negedge clk);
      tr_inrdy.push_back(in_ready_a);
      tr_v.push_back(win_valid_a);
      tr_r.push_back(win_ready_a);
      tr_d.push_back({w00_a, w01_a, w10_a, w11_a});
      if (in_valid_a && in_ready_a) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (win_valid_a && win_ready_a) begin
        obs_w.push_back({w00_a, w01_a, w10_a, w11_a});
        obs_last.push_back(win_last_a);
        obs_cyc.push_back(cyc);
      end
      if (idx >= npix) tail++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid_a  = 1'b0;
    in_pixel_a  = 8'h00;
    win_ready_a = (mode != 3);
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_valid_a  = 1'b0;
    in_pixel_a  = 8'h00;
    win_ready_a = 1'b1;
    in_valid_b  = 1'b0;
    in_pixel_b  = 8'h00;
    win_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (win_valid_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_a: got %b expected 0", win_valid_a); end
    total++;
    if (win_last_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_last_a: got %b expected 0", win_last_a); end
    total++;
    if ({w00_a, w01_a, w10_a, w11_a} !== 32'h0) begin bad++; $display("[TB] FAIL reset_data_a: got %h expected 0", {w00_a, w01_a, w10_a, w11_a}); end
    total++;
    if (in_ready_a !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_a: got %b expected 1", in_ready_a); end
    total++;
    if (win_valid_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_b: got %b expected 0", win_valid_b); end
    total++;
    if ({w00_b, w01_b, w10_b, w11_b} !== 32'h0) begin bad++; $display("[TB] FAIL reset_data_b: got %h expected 0", {w00_b, w01_b, w10_b, w11_b}); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (win_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got valid=%b in_ready=%b expected 0/1", win_valid_a, in_ready_a);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        last;
    int          comp;
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    stream_a(16, 100, 0, 0);
    total++;
    if (obs_w.size() != 4) begin bad++; $display("[TB] FAIL basic_count: got %0d expected 4", obs_w.size()); end
    for (int k = 0; k < 4 && k < obs_w.size(); k++) begin
      expect_win(4, 4, k, d, last, comp);
      total++;
      if (obs_w[k] !== d) begin bad++; $display("[TB] FAIL basic_win%0d: got %h expected %h", k, obs_w[k], d); end
      total++;
      if (obs_last[k] !== last) begin bad++; $display("[TB] FAIL basic_last%0d: got %b expected %b", k, obs_last[k], last); end
      total++;
      if (comp < acc_cyc.size() && obs_cyc[k] != acc_cyc[comp] + 1) begin
        bad++;
        $display("[TB] FAIL basic_latency%0d: got cycle %0d expected %0d", k, obs_cyc[k], acc_cyc[comp] + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic [31:0] d0;
    logic        last;
    int          comp;
    int          stalls;
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    stream_a(16, 100, 1, 5);
    expect_win(4, 4, 0, d0, last, comp);
    stalls = 0;
    for (int c = 0; c < tr_r.size(); c++) begin
      if (tr_r[c] == 1'b0) begin
        stalls++;
        total++;
        if (tr_v[c] !== 1'b1 || tr_d[c] !== d0 || tr_inrdy[c] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL stall_hold c%0d: got v=%b d=%h in_ready=%b expected 1/%h/0", c, tr_v[c], tr_d[c], tr_inrdy[c], d0);
        end
      end
    end
    total++;
    if (stalls != 5) begin bad++; $display("[TB] FAIL stall_cycles: got %0d expected 5", stalls); end
    total++;
    if (acc_cyc.size() != 16) begin bad++; $display("[TB] FAIL stall_pixels: got %0d expected 16", acc_cyc.size()); end
    total++;
    if (obs_w.size() != 4) begin bad++; $display("[TB] FAIL stall_count: got %0d expected 4", obs_w.size()); end
    for (int k = 0; k < 4 && k < obs_w.size(); k++) begin
      expect_win(4, 4, k, d, last, comp);
      total++;
      if (obs_w[k] !== d || obs_last[k] !== last) begin
        bad++;
        $display("[TB] FAIL stall_win%0d: got %h/%b expected %h/%b", k, obs_w[k], obs_last[k], d, last);
      end
    end
  endtask

  task automatic test_gaps();
    logic [31:0] d;
    logic        last;
    int          comp;
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(200 + i));
    stream_a(16, 50, 0, 0);
    total++;
    if (obs_w.size() != 4) begin bad++; $display("[TB] FAIL gaps_count: got %0d expected 4", obs_w.size()); end
    for (int k = 0; k < 4 && k < obs_w.size(); k++) begin
      expect_win(4, 4, k, d, last, comp);
      total++;
      if (obs_w[k] !== d || obs_last[k] !== last) begin
        bad++;
        $display("[TB] FAIL gaps_win%0d: got %h/%b expected %h/%b", k, obs_w[k], obs_last[k], d, last);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        last;
    int          comp;
    src_q.delete();
    for (int i = 0; i < 32; i++) src_q.push_back(8'(i));
    stream_a(32, 100, 0, 0);
    total++;
    if (obs_w.size() != 8) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 8", obs_w.size()); end
    total++;
    if (acc_cyc.size() == 32 && acc_cyc[16] != acc_cyc[15] + 1) begin
      bad++;
      $display("[TB] FAIL b2b_no_idle: got cycle %0d expected %0d", acc_cyc[16], acc_cyc[15] + 1);
    end
    for (int k = 0; k < 8 && k < obs_w.size(); k++) begin
      expect_win(4, 4, k, d, last, comp);
      total++;
      if (obs_w[k] !== d || obs_last[k] !== last) begin
        bad++;
        $display("[TB] FAIL b2b_win%0d: got %h/%b expected %h/%b", k, obs_w[k], obs_last[k], d, last);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic        last;
    int          comp;
    src_q.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(8'(50 + i));
    stream_a(6, 100, 3, 0);
    total++;
    if (win_valid_a !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pending: got %b expected 1", win_valid_a); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (win_valid_a !== 1'b0 || win_last_a !== 1'b0 || in_ready_a !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_outputs: got v=%b last=%b in_ready=%b expected 0/0/1", win_valid_a, win_last_a, in_ready_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(100 + i));
    stream_a(16, 100, 0, 0);
    total++;
    if (obs_w.size() != 4) begin bad++; $display("[TB] FAIL midrst_count: got %0d expected 4", obs_w.size()); end
    for (int k = 0; k < 4 && k < obs_w.size(); k++) begin
      expect_win(4, 4, k, d, last, comp);
      total++;
      if (obs_w[k] !== d || obs_last[k] !== last) begin
        bad++;
        $display("[TB] FAIL midrst_win%0d: got %h/%b expected %h/%b", k, obs_w[k], obs_last[k], d, last);
      end
    end
  endtask

  task automatic test_8x8_toggle();
    logic [31:0] got_w[$];
    logic        got_last[$];
    logic [31:0] d;
    logic        last;
    int          comp;
    int          idx  = 0;
    int          cyc  = 0;
    int          tail = 0;
    src_q.delete();
    for (int i = 0; i < 64; i++) src_q.push_back(8'(i));
    while ((idx < 64 || tail < 6) && cyc < 1000) begin
      in_valid_b  = (idx < 64);
      in_pixel_b  = (idx < 64) ? src_q[idx] : 8'h00;
      win_ready_b = (cyc % 2 == 0);
      @(negedge clk);
      if (in_valid_b && in_ready_b) idx++;
      if (win_valid_b && win_ready_b) begin
        got_w.push_back({w00_b, w01_b, w10_b, w11_b});
        got_last.push_back(win_last_b);
      end
      if (idx >= 64) tail++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid_b  = 1'b0;
    win_ready_b = 1'b1;
    total++;
    if (got_w.size() != 16) begin bad++; $display("[TB] FAIL t8_count: got %0d expected 16", got_w.size()); end
    total++;
    if (got_w.size() > 0 && got_w[0] !== {8'd0, 8'd1, 8'd8, 8'd9}) begin
      bad++;
      $display("[TB] FAIL t8_first: got %h expected 00010809", got_w[0]);
    end
    total++;
    if (got_w.size() == 16 && (got_w[15] !== {8'd54, 8'd55, 8'd62, 8'd63} || got_last[15] !== 1'b1)) begin
      bad++;
      $display("[TB] FAIL t8_final: got %h/%b expected 36373e3f/1", got_w[15], got_last[15]);
    end
    for (int k = 0; k < 16 && k < got_w.size(); k++) begin
      expect_win(8, 8, k, d, last, comp);
      total++;
      if (got_w[k] !== d || got_last[k] !== last) begin
        bad++;
        $display("[TB] FAIL t8_win%0d: got %h/%b expected %h/%b", k, got_w[k], got_last[k], d, last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_8x8_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
